// File: rtl/rom_load_pkg.sv
// Shared types for the ROM-download-to-SDRAM write scheduler.
// Optional build macro used by the top: ROM_LOAD_CHECKSUM_EN.
package rom_load_pkg;

  typedef enum logic [1:0] {
    R68K     = 2'd0,
    RTILES   = 2'd1,
    RSPRITES = 2'd2
  } region_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;
  localparam logic [3:0] BE_ALL = 4'b1111;

  // A lone 16-bit word lands in the low or high half of its 32-bit SDRAM word.
  function automatic entry_t half_entry(input logic [25:0] addr, input logic [15:0] data);
    entry_t e;
    e.addr = addr[25:1];
    if (addr[0]) begin
      e.data = {data, 16'h0};
      e.be   = BE_HI;
    end else begin
      e.data = {16'h0, data};
      e.be   = BE_LO;
    end
    return e;
  endfunction

endpackage

// File: rtl/rom_load_fifo.sv
// Small synchronous FIFO of SDRAM write entries; head is visible the cycle
// after the push edge. A push while full is ignored unless a pop frees a slot.
module rom_load_fifo
  import rom_load_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  entry_t                 din_i,
  input  logic                   pop_i,
  output entry_t                 dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents need no reset since occupancy qualifies them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/rom_load_sdram_sched.sv
// ROM download write scheduler: packs tile/sprite word pairs, queues 32-bit
// SDRAM writes, throttles the HPS via ioctl_wait and reports completion.
// Optional macro ROM_LOAD_CHECKSUM_EN enables the running 16-bit checksum.
module rom_load_sdram_sched
  import rom_load_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WAIT_MARGIN = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        load_en,
  input  logic        wr_68k,
  input  logic        wr_tiles,
  input  logic        wr_sprites,
  input  logic [25:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        ioctl_wait,
  output logic        sdr_req,
  input  logic        sdr_ack,
  output logic [24:0] sdr_addr,
  output logic [31:0] sdr_data,
  output logic [3:0]  sdr_be,
  output logic        load_done,
  output logic        err,
  output logic [15:0] checksum
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] WAIT_TH = (CW+1)'(DEPTH - WAIT_MARGIN);

  state_t        state_q, state_d;
  logic          in_load, flush_pack;
  logic          sel_68k, sel_tile, sel_spr, collide;
  region_t       word_reg;
  logic          pack_vld_q, pack_vld_d;
  logic [25:0]   pack_addr_q, pack_addr_d;
  logic [15:0]   pack_data_q, pack_data_d;
  region_t       pack_reg_q, pack_reg_d;
  logic          flush_vld, new_vld;
  entry_t        flush_ent, new_ent;
  logic          skid_vld_q, skid_vld_d;
  entry_t        skid_q, skid_d;
  logic          push_vld, push_ok, drop3, overflow, pop;
  entry_t        push_ent, head;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic [CW:0]   occ_d;
  logic          req_q, req_d, err_q, err_d, wait_q, wait_d;

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: done only once nothing is held, queued or in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load_en) state_d = S_LOAD;
      S_LOAD:  if (!load_en) state_d = S_FLUSH;
      S_FLUSH: if (load_en) state_d = S_LOAD;
               else if (!pack_vld_q && !skid_vld_q && fifo_empty && !req_q) state_d = S_DONE;
      S_DONE:  if (load_en) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_load    = 1'b0;
    flush_pack = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      S_LOAD:  in_load    = 1'b1;
      S_FLUSH: flush_pack = 1'b1;
      S_DONE:  load_done  = 1'b1;
      default: ;
    endcase
  end

  // Strobe arbitration: 68k beats tiles beats sprites; losers only flag err.
  always_comb begin
    sel_68k  = in_load && wr_68k;
    sel_tile = in_load && !wr_68k && wr_tiles;
    sel_spr  = in_load && !wr_68k && !wr_tiles && wr_sprites;
    collide  = in_load && ((wr_68k && (wr_tiles || wr_sprites)) || (wr_tiles && wr_sprites));
    word_reg = sel_tile ? RTILES : RSPRITES;
  end

  // Pack register update and generation of flush/new candidate entries.
  always_comb begin
    pack_vld_d  = pack_vld_q;
    pack_addr_d = pack_addr_q;
    pack_data_d = pack_data_q;
    pack_reg_d  = pack_reg_q;
    flush_vld   = 1'b0;
    flush_ent   = half_entry(pack_addr_q, pack_data_q);
    new_vld     = 1'b0;
    new_ent     = half_entry(wr_addr, wr_data);
    if (sel_68k) begin
      new_vld = 1'b1;
    end else if (sel_tile || sel_spr) begin
      if (!wr_addr[0]) begin
        flush_vld   = pack_vld_q;
        pack_vld_d  = 1'b1;
        pack_addr_d = wr_addr;
        pack_data_d = wr_data;
        pack_reg_d  = word_reg;
      end else begin
        pack_vld_d = 1'b0;
        new_vld    = 1'b1;
        // Held word is always even, so matching upper bits means addr-1.
        if (pack_vld_q && pack_reg_q == word_reg && pack_addr_q[25:1] == wr_addr[25:1]) begin
          new_ent.data = {wr_data, pack_data_q};
          new_ent.be   = BE_ALL;
        end else begin
          flush_vld = pack_vld_q;
        end
      end
    end else if (flush_pack) begin
      flush_vld  = pack_vld_q;
      pack_vld_d = 1'b0;
    end
  end

  // Ordering: skid (oldest) then flush then new; one goes to the FIFO, the
  // next waits in the skid register.
  always_comb begin
    push_vld   = 1'b0;
    push_ent   = new_ent;
    skid_vld_d = 1'b0;
    skid_d     = skid_q;
    drop3      = 1'b0;
    if (skid_vld_q) begin
      push_vld = 1'b1;
      push_ent = skid_q;
      if (flush_vld) begin
        skid_vld_d = 1'b1;
        skid_d     = flush_ent;
        drop3      = new_vld;
      end else if (new_vld) begin
        skid_vld_d = 1'b1;
        skid_d     = new_ent;
      end
    end else if (flush_vld) begin
      push_vld = 1'b1;
      push_ent = flush_ent;
      if (new_vld) begin
        skid_vld_d = 1'b1;
        skid_d     = new_ent;
      end
    end else if (new_vld) begin
      push_vld = 1'b1;
    end
  end

  rom_load_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_sys),
    .rst_n_i (reset),
    .push_i  (push_vld),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Handshake, error and back-pressure next-state logic.
  always_comb begin
    pop      = req_q && sdr_ack;
    push_ok  = push_vld && (!fifo_full || pop);
    overflow = push_vld && fifo_full && !pop;
    req_d    = req_q;
    if (pop)                         req_d = 1'b0;
    else if (!req_q && !fifo_empty)  req_d = 1'b1;
    err_d  = err_q || collide || overflow || drop3;
    occ_d  = {1'b0, fifo_cnt} + (CW+1)'(push_ok) - (CW+1)'(pop) + (CW+1)'(skid_vld_d);
    wait_d = load_en && (occ_d >= WAIT_TH);
  end

  // Control registers.
  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      pack_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      pack_vld_q <= pack_vld_d;
      skid_vld_q <= skid_vld_d;
      req_q      <= req_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
    end
  end

  // Data registers, qualified by their valid flags.
  always_ff @(posedge clk_sys) begin
    pack_addr_q <= pack_addr_d;
    pack_data_q <= pack_data_d;
    pack_reg_q  <= pack_reg_d;
    skid_q      <= skid_d;
  end

  assign sdr_req    = req_q;
  assign sdr_addr   = req_q ? head.addr : '0;
  assign sdr_data   = req_q ? head.data : '0;
  assign sdr_be     = req_q ? head.be   : '0;
  assign ioctl_wait = wait_q;
  assign err        = err_q;

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Running sum of accepted words; restarts when a new download begins.
  always_comb begin
    csum_d = csum_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && load_en) csum_d = '0;
    else if (sel_68k || sel_tile || sel_spr)                  csum_d = csum_q + wr_data;
  end

  // Checksum register.
  always_ff @(posedge clk_sys) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0;
`endif

endmodule

// File: tb/tb_rom_load_sdram_sched.sv
// Scoreboard bench for rom_load_sdram_sched (default DEPTH=4, WAIT_MARGIN=2).
module tb_rom_load_sdram_sched;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic        wr_68k = 1'b0, wr_tiles = 1'b0, wr_sprites = 1'b0;
  logic [25:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        sdr_ack = 1'b0;
  logic        ioctl_wait, sdr_req, load_done, err;
  logic [24:0] sdr_addr;
  logic [31:0] sdr_data;
  logic [3:0]  sdr_be;
  logic [15:0] checksum;

  typedef struct packed {
    logic [24:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acks = 0;
  bit   ack_en = 1'b0;

  always #5 clk_sys = ~clk_sys;

  rom_load_sdram_sched dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .load_en    (load_en),
    .wr_68k     (wr_68k),
    .wr_tiles   (wr_tiles),
    .wr_sprites (wr_sprites),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ioctl_wait (ioctl_wait),
    .sdr_req    (sdr_req),
    .sdr_ack    (sdr_ack),
    .sdr_addr   (sdr_addr),
    .sdr_data   (sdr_data),
    .sdr_be     (sdr_be),
    .load_done  (load_done),
    .err        (err),
    .checksum   (checksum)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, want);
  endtask

  // Monitor + SDRAM responder: when a request is accepted, compare it with the
  // oldest expected write and ack it for one cycle.
  always @(negedge clk_sys) begin
    if (sdr_req && !sdr_ack && ack_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %h data %h be %h, required none",
                 sdr_addr, sdr_data, sdr_be);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(sdr_addr), 64'(mon_e.a));
        check("wr_data", 64'(sdr_data), 64'(mon_e.d));
        check("wr_be",   64'(sdr_be),   64'(mon_e.be));
      end
      n_acks++;
      sdr_ack = 1'b1;
    end else begin
      sdr_ack = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input int kind, input logic [25:0] a, input logic [15:0] d);
    wr_addr    = a;
    wr_data    = d;
    wr_68k     = (kind == 0);
    wr_tiles   = (kind == 1);
    wr_sprites = (kind == 2);
    tick();
    wr_68k     = 1'b0;
    wr_tiles   = 1'b0;
    wr_sprites = 1'b0;
  endtask

  task automatic expect_wr(input logic [24:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    e.a = a; e.d = d; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || sdr_req) && i < budget) begin
      tick();
      i++;
    end
    check(name, 64'(i < budget), 64'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (!load_done && i < budget) begin
      tick();
      i++;
    end
    check(name, 64'(load_done), 64'd1);
  endtask

  initial begin
    int base_acks;
    int req_seen;
    int i;

    // Reset state.
    repeat (3) tick();
    check("rst_sdr_req",    64'(sdr_req),    64'd0);
    check("rst_ioctl_wait", 64'(ioctl_wait), 64'd0);
    check("rst_load_done",  64'(load_done),  64'd0);
    check("rst_err",        64'(err),        64'd0);
    check("rst_checksum",   64'(checksum),   64'd0);
    check("rst_sdr_be",     64'(sdr_be),     64'd0);
    reset   = 1'b1;
    ack_en  = 1'b1;
    load_en = 1'b1;
    tick();

    // Tile pair packs into one full write.
    expect_wr(25'h400000, 32'h2222_1111, 4'hF);
    strobe(1, 26'h0800000, 16'h1111);
    strobe(1, 26'h0800001, 16'h2222);
    wait_drain("drain_tiles", 40);

    // 68k odd and even words.
    expect_wr(25'h000001, 32'hBEEF_0000, 4'hC);
    strobe(0, 26'h0000003, 16'hBEEF);
    expect_wr(25'h000008, 32'h0000_1234, 4'h3);
    strobe(0, 26'h0000010, 16'h1234);
    wait_drain("drain_68k", 40);

    // Held tile word, then an odd sprite word: two half writes via the skid.
    expect_wr(25'h400008, 32'h0000_AAAA, 4'h3);
    expect_wr(25'h400008, 32'hBBBB_0000, 4'hC);
    strobe(1, 26'h0800010, 16'hAAAA);
    strobe(2, 26'h0800011, 16'hBBBB);
    wait_drain("drain_skid", 40);

    // Even after even flushes the first; the second pairs with its odd.
    expect_wr(25'h400010, 32'h0000_0001, 4'h3);
    expect_wr(25'h400011, 32'h0003_0002, 4'hF);
    strobe(1, 26'h0800020, 16'h0001);
    strobe(1, 26'h0800022, 16'h0002);
    strobe(1, 26'h0800023, 16'h0003);
    wait_drain("drain_reflush", 40);
    check("err_clean", 64'(err), 64'd0);

    // Orphan sprite word flushed when the download ends.
    expect_wr(25'h480008, 32'h0000_5555, 4'h3);
    strobe(2, 26'h0900010, 16'h5555);
    load_en = 1'b0;
    tick();
    check("load_done_early", 64'(load_done), 64'd0);
    wait_done("load_done_rise", 40);
    check("orphan_drained", 64'(exp_q.size()), 64'd0);
    check("err_after_orphan", 64'(err), 64'd0);

    // Restart clears load_done; simultaneous 68k and tile strobes.
    load_en = 1'b1;
    tick();
    check("load_done_clear", 64'(load_done), 64'd0);
    expect_wr(25'h000010, 32'h0000_7777, 4'h3);
    wr_addr  = 26'h0000020;
    wr_data  = 16'h7777;
    wr_68k   = 1'b1;
    wr_tiles = 1'b1;
    tick();
    wr_68k   = 1'b0;
    wr_tiles = 1'b0;
    check("collision_err", 64'(err), 64'd1);
    wait_drain("drain_collision", 40);
    load_en = 1'b0;
    wait_done("collision_done", 40);

    // Overflow with acks held off.
    reset = 1'b0;
    repeat (2) tick();
    reset   = 1'b1;
    check("err_cleared", 64'(err), 64'd0);
    ack_en  = 1'b0;
    load_en = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) expect_wr(25'h000100 + 25'(k), 32'h0000_1000 + 32'(k), 4'h3);
      strobe(0, 26'h0000200 + 26'(2 * k), 16'h1000 + 16'(k));
      check($sformatf("ovf_wait_%0d", k), 64'(ioctl_wait), 64'((k + 1) >= 2));
      check($sformatf("ovf_err_%0d", k),  64'(err),        64'(k == 4));
    end
    base_acks = n_acks;
    ack_en = 1'b1;
    wait_drain("drain_overflow", 60);
    repeat (10) tick();
    check("overflow_drain_count", 64'(n_acks - base_acks), 64'd4);

    // Reset while a request is pending.
    ack_en = 1'b0;
    strobe(0, 26'h0000040, 16'h9999);
    i = 0;
    while (!sdr_req && i < 10) begin
      tick();
      i++;
    end
    check("req_before_reset", 64'(sdr_req), 64'd1);
    reset = 1'b0;
    tick();
    check("midrst_sdr_req",    64'(sdr_req),    64'd0);
    check("midrst_load_done",  64'(load_done),  64'd0);
    check("midrst_checksum",   64'(checksum),   64'd0);
    check("midrst_ioctl_wait", 64'(ioctl_wait), 64'd0);
    check("midrst_err",        64'(err),        64'd0);
    exp_q.delete();
    reset  = 1'b1;
    ack_en = 1'b1;
    req_seen = 0;
    repeat (10) begin
      tick();
      if (sdr_req) req_seen++;
    end
    check("fifo_empty_after_reset", 64'(req_seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
